// File: rtl/qlk0r_muldiv_seq_if.sv
// Handshake/bus bundle between the CPU SFR block (master) and the
// iterative multiply/divide unit (slave).
// Optional macro: MULDIV_MAC_EN adds the accumulate request and overflow flag.
interface qlk0r_muldiv_seq_if #(parameter int WIDTH = 16);
  logic             start_i;
  logic             mdsm_i;
  logic             mddiv_i;
  logic [WIDTH-1:0] opa_i;
  logic [WIDTH-1:0] opb_i;
  logic [WIDTH-1:0] reslo_o;
  logic [WIDTH-1:0] reshi_o;
  logic             busy_o;
  logic             done_o;
  logic             dzero_o;
`ifdef MULDIV_MAC_EN
  logic             mdacc_i;
  logic             accov_o;

  modport master (output start_i, mdsm_i, mddiv_i, opa_i, opb_i, mdacc_i,
                  input  reslo_o, reshi_o, busy_o, done_o, dzero_o, accov_o);
  modport slave  (input  start_i, mdsm_i, mddiv_i, opa_i, opb_i, mdacc_i,
                  output reslo_o, reshi_o, busy_o, done_o, dzero_o, accov_o);
`else
  modport master (output start_i, mdsm_i, mddiv_i, opa_i, opb_i,
                  input  reslo_o, reshi_o, busy_o, done_o, dzero_o);
  modport slave  (input  start_i, mdsm_i, mddiv_i, opa_i, opb_i,
                  output reslo_o, reshi_o, busy_o, done_o, dzero_o);
`endif
endinterface

// File: rtl/qlk0r_muldiv_seq.sv
// Iterative radix-2 multiply/divide unit with START/BUSY/DONE handshake.
// Multiply: shift-add over WIDTH cycles; divide: restoring, WIDTH cycles.
// Signed operands are reduced to magnitudes at accept; the sign is fixed up
// in a single FIX cycle that also writes the result registers.
// Optional macro: MULDIV_MAC_EN enables multiply-accumulate (mdacc_i/accov_o).
module qlk0r_muldiv_seq #(
  parameter int WIDTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  qlk0r_muldiv_seq_if.slave bus
);
  localparam int CW = ($clog2(WIDTH + 1) > 5) ? $clog2(WIDTH + 1) : 5;
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q;      // mul: partial product high; div: remainder
  logic [WIDTH-1:0] lo_q;      // mul: multiplier/product low; div: quotient
  logic [WIDTH-1:0] magb_q;    // |OPB|: addend for mul, divisor for div
  logic [WIDTH-1:0] opa_q;     // raw dividend, returned as remainder on /0
  logic [WIDTH-1:0] reslo_q;
  logic [WIDTH-1:0] reshi_q;
  logic             div_q;
  logic             nega_q;
  logic             negb_q;
  logic             busy_q;
  logic             done_q;
  logic             dzero_q;
`ifdef MULDIV_MAC_EN
  logic             mac_q;
  logic             sgn_q;
  logic             accov_q;
  logic [W2:0]      acc_s;
  logic             ov_s;
`endif

  logic             accept_s;
  logic [WIDTH-1:0] maga_s;
  logic [WIDTH-1:0] magb_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   shl_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] hi_step_s;
  logic [WIDTH-1:0] lo_step_s;
  logic [WIDTH-1:0] quo_s;
  logic [WIDTH-1:0] rem_s;
  logic [W2-1:0]    raw_s;
  logic [W2-1:0]    res_s;

  assign accept_s = bus.start_i && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Operand magnitudes presented during the accept cycle
  always_comb begin
    maga_s = bus.opa_i;
    magb_s = bus.opb_i;
    if (bus.mdsm_i && bus.opa_i[WIDTH-1]) begin
      maga_s = -bus.opa_i;
    end else begin
      maga_s = bus.opa_i;
    end
    if (bus.mdsm_i && bus.opb_i[WIDTH-1]) begin
      magb_s = -bus.opb_i;
    end else begin
      magb_s = bus.opb_i;
    end
  end

  // One iteration step: shift-add for multiply, restoring subtract for divide
  always_comb begin
    sum_s     = {1'b0, hi_q} + {1'b0, magb_q};
    shl_s     = {hi_q, lo_q[WIDTH-1]};
    diff_s    = shl_s[WIDTH-1:0] - magb_q;
    hi_step_s = hi_q;
    lo_step_s = lo_q;
    if (div_q) begin
      if (shl_s >= {1'b0, magb_q}) begin
        hi_step_s = diff_s;
        lo_step_s = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_step_s = shl_s[WIDTH-1:0];
        lo_step_s = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else if (lo_q[0]) begin
      hi_step_s = sum_s[WIDTH:1];
      lo_step_s = {sum_s[0], lo_q[WIDTH-1:1]};
    end else begin
      hi_step_s = {1'b0, hi_q[WIDTH-1:1]};
      lo_step_s = {hi_q[0], lo_q[WIDTH-1:1]};
    end
  end

  // Sign correction and divide-by-zero substitution of the final result
  always_comb begin
    raw_s = {hi_q, lo_q};
    quo_s = (nega_q ^ negb_q) ? -lo_q : lo_q;
    rem_s = nega_q ? -hi_q : hi_q;
    if (!div_q) begin
      res_s = (nega_q ^ negb_q) ? -raw_s : raw_s;
    end else if (magb_q == {WIDTH{1'b0}}) begin
      res_s = {opa_q, {WIDTH{1'b1}}};
    end else begin
      res_s = {rem_s, quo_s};
    end
  end

`ifdef MULDIV_MAC_EN
  // Accumulated sum and its overflow (carry-out unsigned, sign flip signed)
  always_comb begin
    acc_s = {1'b0, reshi_q, reslo_q} + {1'b0, res_s};
    if (sgn_q) begin
      ov_s = (reshi_q[WIDTH-1] == res_s[W2-1]) && (acc_s[W2-1] != reshi_q[WIDTH-1]);
    end else begin
      ov_s = acc_s[W2];
    end
  end
`endif

  // Control FSM with datapath and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      magb_q  <= {WIDTH{1'b0}};
      opa_q   <= {WIDTH{1'b0}};
      reslo_q <= {WIDTH{1'b0}};
      reshi_q <= {WIDTH{1'b0}};
      div_q   <= 1'b0;
      nega_q  <= 1'b0;
      negb_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dzero_q <= 1'b0;
`ifdef MULDIV_MAC_EN
      mac_q   <= 1'b0;
      sgn_q   <= 1'b0;
      accov_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (accept_s) begin
            state_q <= S_CALC;
            busy_q  <= 1'b1;
            cnt_q   <= {CW{1'b0}};
            div_q   <= bus.mddiv_i;
            nega_q  <= bus.mdsm_i && bus.opa_i[WIDTH-1];
            negb_q  <= bus.mdsm_i && bus.opb_i[WIDTH-1];
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= maga_s;
            magb_q  <= magb_s;
            opa_q   <= bus.opa_i;
            dzero_q <= 1'b0;
`ifdef MULDIV_MAC_EN
            mac_q   <= bus.mdacc_i && !bus.mddiv_i;
            sgn_q   <= bus.mdsm_i;
            accov_q <= 1'b0;
`endif
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CALC: begin
          hi_q  <= hi_step_s;
          lo_q  <= lo_step_s;
          cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= S_FIX;
          end else begin
            state_q <= S_CALC;
          end
        end
        S_FIX: begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          dzero_q <= div_q && (magb_q == {WIDTH{1'b0}});
`ifdef MULDIV_MAC_EN
          if (mac_q) begin
            reshi_q <= acc_s[W2-1:WIDTH];
            reslo_q <= acc_s[WIDTH-1:0];
            accov_q <= ov_s;
          end else begin
            reshi_q <= res_s[W2-1:WIDTH];
            reslo_q <= res_s[WIDTH-1:0];
            accov_q <= 1'b0;
          end
`else
          reshi_q <= res_s[W2-1:WIDTH];
          reslo_q <= res_s[WIDTH-1:0];
`endif
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.reslo_o = reslo_q;
  assign bus.reshi_o = reshi_q;
  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;
  assign bus.dzero_o = dzero_q;
`ifdef MULDIV_MAC_EN
  assign bus.accov_o = accov_q;
`endif

endmodule

// File: tb/tb_qlk0r_muldiv_seq.sv
// Self-checking bench for qlk0r_muldiv_seq (WIDTH=16): vector table plus
// hand-written sequences for reset abort, START-while-busy, /0 stickiness
// and (with MULDIV_MAC_EN) accumulation. Expected results go through a queue.
module tb_qlk0r_muldiv_seq;
  localparam int W = 16;

  typedef struct {
    string       name;
    logic        sm;
    logic        dv;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dz;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dz;
    logic        ov;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [15:0] prev_lo = 16'h0000;
  exp_t        sb_q[$];
  vec_t        vecs[$];

  qlk0r_muldiv_seq_if #(.WIDTH(W)) bus ();

  qlk0r_muldiv_seq #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input string nm, input logic sm, input logic dv, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] hi, input logic [15:0] lo,
                         input logic dz);
    vec_t v;
    v.name = nm; v.sm = sm; v.dv = dv; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.dz = dz;
    vecs.push_back(v);
  endtask

  // Called at a negedge with start already driven; waits for DONE and scores.
  task automatic wait_done(input int poke, output int lat, output int busy_n);
    exp_t e;
    bit   got;
    got    = 1'b0;
    lat    = 0;
    busy_n = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (i == 0) begin
        bus.start_i = 1'b0;
        bus.opa_i   = 16'($urandom);
        bus.opb_i   = 16'($urandom);
      end else if (poke > 0 && i == poke) begin
        chk("hold_reslo_busy", bus.reslo_o, prev_lo);
        bus.start_i = 1'b1;
        bus.opa_i   = 16'h0007;
        bus.opb_i   = 16'h0007;
      end else if (poke > 0 && i == poke + 1) begin
        bus.start_i = 1'b0;
      end
      if (bus.done_o) begin
        got = 1'b1;
      end else if (bus.busy_o) begin
        busy_n++;
      end
    end
    if (sb_q.size() == 0) begin
      n_chk++;
      $display("FAIL scoreboard_empty: got 0 entries, want 1");
    end else begin
      e = sb_q.pop_front();
      if (!got) begin
        n_chk++;
        $display("FAIL %s_timeout: got no DONE, want DONE within 100 cycles", e.name);
      end else begin
        chk({e.name, "_hi"}, bus.reshi_o, e.hi);
        chk({e.name, "_lo"}, bus.reslo_o, e.lo);
        chk({e.name, "_dz"}, bus.dzero_o, e.dz);
`ifdef MULDIV_MAC_EN
        chk({e.name, "_ov"}, bus.accov_o, e.ov);
`endif
        prev_lo = e.lo;
      end
    end
  endtask

  task automatic run_op(input string nm, input logic sm, input logic dv, input logic [15:0] a,
                        input logic [15:0] b, input logic acc, input logic [15:0] ehi,
                        input logic [15:0] elo, input logic edz, input logic eov, input int poke);
    exp_t e;
    int   lat;
    int   bn;
    e.name = nm; e.hi = ehi; e.lo = elo; e.dz = edz; e.ov = eov;
    sb_q.push_back(e);
    bus.mdsm_i  = sm;
    bus.mddiv_i = dv;
    bus.opa_i   = a;
    bus.opb_i   = b;
`ifdef MULDIV_MAC_EN
    bus.mdacc_i = acc;
`else
    if (acc) begin
      bus.start_i = 1'b1;
    end else begin
      bus.start_i = 1'b1;
    end
`endif
    bus.start_i = 1'b1;
    wait_done(poke, lat, bn);
    chk({nm, "_latency"}, lat, 18);
    chk({nm, "_busy_cycles"}, bn, 17);
  endtask

  initial begin
    int seen;
    add_vec("u_ffff_x_ffff", 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0);
    add_vec("s_ffff_x_ffff", 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 1'b0);
    add_vec("s_8000_x_8000", 1'b1, 1'b0, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0);
    add_vec("u_1234_x_5678", 1'b0, 1'b0, 16'h1234, 16'h5678, 16'h0626, 16'h0060, 1'b0);
    add_vec("s_m7_x_3",      1'b1, 1'b0, 16'hFFF9, 16'h0003, 16'hFFFF, 16'hFFEB, 1'b0);
    add_vec("u_100_d_7",     1'b0, 1'b1, 16'd100,  16'd7,    16'd2,    16'd14,   1'b0);
    add_vec("s_m100_d_7",    1'b1, 1'b1, 16'hFF9C, 16'h0007, 16'hFFFE, 16'hFFF2, 1'b0);
    add_vec("s_100_d_m7",    1'b1, 1'b1, 16'h0064, 16'hFFF9, 16'h0002, 16'hFFF2, 1'b0);
    add_vec("s_m7_d_2",      1'b1, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0);
    add_vec("s_8000_d_m1",   1'b1, 1'b1, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0);
    add_vec("u_abcd_d_0123", 1'b0, 1'b1, 16'hABCD, 16'h0123, 16'h0028, 16'h0097, 1'b0);
    add_vec("u_ffff_d_1",    1'b0, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0);
    add_vec("u_1234_d_0",    1'b0, 1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1);
    add_vec("u_6_d_3",       1'b0, 1'b1, 16'd6,    16'd3,    16'd0,    16'd2,    1'b0);
    add_vec("s_8000_d_0",    1'b1, 1'b1, 16'h8000, 16'h0000, 16'h8000, 16'hFFFF, 1'b1);

    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.mdsm_i  = 1'b0;
    bus.mddiv_i = 1'b0;
    bus.opa_i   = 16'h0000;
    bus.opb_i   = 16'h0000;
`ifdef MULDIV_MAC_EN
    bus.mdacc_i = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_reslo", bus.reslo_o, 16'h0000);
    chk("rst_reshi", bus.reshi_o, 16'h0000);
    chk("rst_busy",  bus.busy_o,  1'b0);
    chk("rst_done",  bus.done_o,  1'b0);
    chk("rst_dzero", bus.dzero_o, 1'b0);

    // Table: odd entries issued back-to-back from the DONE cycle, even ones after idle gaps
    for (int i = 0; i < vecs.size(); i++) begin
      if (i % 2 == 0) begin
        repeat (2) @(negedge clk);
      end
      run_op(vecs[i].name, vecs[i].sm, vecs[i].dv, vecs[i].a, vecs[i].b, 1'b0,
             vecs[i].hi, vecs[i].lo, vecs[i].dz, 1'b0, 0);
    end

    // Divide-by-zero flag and result are held in IDLE
    run_op("u_1234_d_0_again", 1'b0, 1'b1, 16'h1234, 16'h0000, 1'b0, 16'h1234, 16'hFFFF, 1'b1, 1'b0, 0);
    repeat (3) @(negedge clk);
    chk("dz_sticky_dzero", bus.dzero_o, 1'b1);
    chk("dz_sticky_reshi", bus.reshi_o, 16'h1234);
    chk("dz_sticky_done",  bus.done_o,  1'b0);

    // Reset in the fifth cycle of a multiply aborts it
    bus.mdsm_i  = 1'b0;
    bus.mddiv_i = 1'b0;
    bus.opa_i   = 16'h1234;
    bus.opb_i   = 16'h5678;
    bus.start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_reslo", bus.reslo_o, 16'h0000);
    chk("abort_reshi", bus.reshi_o, 16'h0000);
    chk("abort_busy",  bus.busy_o,  1'b0);
    chk("abort_done",  bus.done_o,  1'b0);
    chk("abort_dzero", bus.dzero_o, 1'b0);
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.done_o || bus.busy_o) begin
        seen = 1;
      end
    end
    chk("abort_stays_idle", seen, 0);

    // START pulse while busy is ignored and the old result is held
    run_op("u_6_d_3_pre", 1'b0, 1'b1, 16'd6, 16'd3, 1'b0, 16'd0, 16'd2, 1'b0, 1'b0, 0);
    @(negedge clk);
    run_op("u_3_x_5_poked", 1'b0, 1'b0, 16'd3, 16'd5, 1'b0, 16'd0, 16'd15, 1'b0, 1'b0, 4);
    repeat (2) @(negedge clk);
    chk("poke_no_restart_busy", bus.busy_o, 1'b0);
    chk("poke_no_restart_lo",   bus.reslo_o, 16'd15);

`ifdef MULDIV_MAC_EN
    run_op("mac_clear",  1'b0, 1'b0, 16'd0,    16'd0,    1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 0);
    run_op("mac_3x4_a",  1'b0, 1'b0, 16'd3,    16'd4,    1'b1, 16'h0000, 16'd12,   1'b0, 1'b0, 0);
    run_op("mac_3x4_b",  1'b0, 1'b0, 16'd3,    16'd4,    1'b1, 16'h0000, 16'd24,   1'b0, 1'b0, 0);
    run_op("mac_set",    1'b0, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 0);
    run_op("mac_big",    1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 0);
    run_op("mac_full",   1'b0, 1'b0, 16'hFFFF, 16'h0001, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 0);
    run_op("mac_wrap",   1'b0, 1'b0, 16'h0001, 16'h0001, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 0);
    run_op("mac_div_ig", 1'b0, 1'b1, 16'd5,    16'd1,    1'b1, 16'h0000, 16'd5,    1'b0, 1'b0, 0);
    run_op("smac_set",   1'b1, 1'b0, 16'h7FFF, 16'h7FFF, 1'b0, 16'h3FFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op("smac_ok",    1'b1, 1'b0, 16'h7FFF, 16'h7FFF, 1'b1, 16'h7FFE, 16'h0002, 1'b0, 1'b0, 0);
    run_op("smac_ovf",   1'b1, 1'b0, 16'h7FFF, 16'h7FFF, 1'b1, 16'hBFFD, 16'h0003, 1'b0, 1'b1, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
